dmem_b_store_buf: RTL
=====================

DMEM_B_STORE_BUF -- requirements
Module: dmem_b_store_buf

Interface
REQ-001 Parameter DEPTH, default 4, store-buffer entries (power of two, 2..16).
REQ-002 Parameter DROP_W, default 8, width of rejected-store counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 addr_b  input  32  byte address from memory-access stage; word address = addr_b[31:2], addr_b[1:0] ignored.
REQ-006 addr_b_start  input  4  byte-lane write enables; nonzero = store request, zero = load/idle.
REQ-007 addr_b_write  input  32  store data, lane i = bits [8i+7:8i].
REQ-008 addr_b_read  output  32  combinational load data for addr_b.
REQ-009 buf_full  output  1  high when entry count == DEPTH.
REQ-010 buf_empty  output  1  high when entry count == 0.
REQ-011 mem_req  output  1  drain request to data SRAM write port.
REQ-012 mem_ack  input  1  SRAM accepts current drain entry this cycle.
REQ-013 mem_waddr  output  30  word address of head entry.
REQ-014 mem_be  output  4  byte enables of head entry.
REQ-015 mem_wdata  output  32  data of head entry.
REQ-016 mem_raddr  output  30  SRAM read word address, equals addr_b[31:2] combinationally.
REQ-017 mem_rdata  input  32  SRAM combinational read data for mem_raddr.
REQ-018 drop_cnt  output  DROP_W  count of rejected stores.

Function
REQ-019 Buffer SHALL be a FIFO of DEPTH entries {word addr[29:0], be[3:0], data[31:0]} with head/tail pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-020 Push SHALL occur on a clock edge when addr_b_start != 0 and (count < DEPTH or pop occurs that cycle); entry = {addr_b[31:2], addr_b_start, addr_b_write}.
REQ-021 mem_req SHALL equal !buf_empty; mem_waddr/mem_be/mem_wdata SHALL reflect the head entry and hold stable until popped.
REQ-022 Pop SHALL occur on a clock edge when mem_req && mem_ack; mem_ack while empty SHALL be ignored.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; when full this SHALL accept the new store (no drop).
REQ-024 Store with count == DEPTH and no pop SHALL be rejected, buffer unchanged, drop_cnt incremented, saturating at all-ones.
REQ-025 addr_b_read lane i SHALL be lane i of the youngest valid entry whose word address == addr_b[31:2] and be[i] == 1; if none, lane i of mem_rdata.
REQ-026 Forwarding SHALL use buffer state before the current edge; a store presented in the same cycle is not forwarded to itself.
REQ-027 Entries SHALL drain strictly in push order; two stores to one word SHALL both be written, older first.
REQ-028 Drain latency: an entry pushed into an empty buffer SHALL appear on mem_req the next cycle; with mem_ack held high, one entry retires per cycle.
REQ-029 buf_full, buf_empty SHALL be derived from the registered count only.

Reset
REQ-030 On rst_n low, immediately: count = 0, head = tail = 0, drop_cnt = 0, buf_empty = 1, buf_full = 0, mem_req = 0.
REQ-031 Reset mid-drain SHALL discard all pending entries; no write reaches SRAM after reset assertion.
REQ-032 Entry storage contents need not be reset; valid tracking SHALL ensure stale entries never forward.
REQ-033 After rst_n rises, first push SHALL be accepted on the next rising edge.

Verification
REQ-034 Store addr 0x100, be 4'b1111, data 0xDEADBEEF, mem_ack=0; next cycle load 0x100 with mem_rdata 0 -> addr_b_read 0xDEADBEEF, mem_req 1, mem_waddr 0x40.
REQ-035 Store 0x104 be 4'b0001 data 0x000000AA, mem_rdata 0x11223344 -> load 0x104 returns 0x112233AA.
REQ-036 Two stores to 0x200 (0x1111_1111 be 1111, then 0x2222_2222 be 0011) -> load returns 0x11112222; with mem_ack=1 drain order 0x11111111 then 0x22222222.
REQ-037 Fill 4 entries, mem_ack=0, fifth store -> rejected, drop_cnt 1, buf_full 1; repeat with mem_ack=1 -> accepted, count stays 4, drop_cnt unchanged.
REQ-038 Three entries queued, assert rst_n low mid-cycle -> mem_req 0 and buf_empty 1 without a clock edge; no further mem_req after release.
REQ-039 Saturation: DROP_W=2, six rejected stores -> drop_cnt stays 3.

Source files
------------

// File: rtl/dmem_b_store_buf.sv
// Data-memory store buffer: queues byte-masked stores in a FIFO that drains to the
// SRAM write port, and forwards pending store bytes to same-cycle loads.
module dmem_b_store_buf #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       addr_b,
    input  logic [3:0]        addr_b_start,
    input  logic [31:0]       addr_b_write,
    output logic [31:0]       addr_b_read,
    output logic              buf_full,
    output logic              buf_empty,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [29:0]       mem_waddr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    output logic [29:0]       mem_raddr,
    input  logic [31:0]       mem_rdata,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [29:0]       addr_mem [DEPTH];
    logic [3:0]        be_mem   [DEPTH];
    logic [31:0]       data_mem [DEPTH];

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              store_s;
    logic              full_s;
    logic              empty_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic [PTR_W-1:0]  age_slot_s [DEPTH];
    logic [31:0]       fwd_data_s;

    assign full_s  = (count_q == CNT_W'(DEPTH));
    assign empty_s = (count_q == {CNT_W{1'b0}});
    assign store_s = (addr_b_start != 4'b0000);
    assign pop_s   = !empty_s && mem_ack;
    assign push_s  = store_s && (!full_s || pop_s);
    assign drop_s  = store_s && full_s && !pop_s;

    // Pointer, count, valid and drop-counter next state; a pop frees its slot before a push may reuse it.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        drop_d  = drop_q;
        if (pop_s) begin
            head_d          = head_q + PTR_W'(1);
            valid_d[head_q] = 1'b0;
        end else begin
            head_d = head_q;
        end
        if (push_s) begin
            tail_d          = tail_q + PTR_W'(1);
            valid_d[tail_q] = 1'b1;
        end else begin
            tail_d = tail_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (drop_s && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + DROP_W'(1);
        end else begin
            drop_d = drop_q;
        end
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= {DEPTH{1'b0}};
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
            drop_q  <= {DROP_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Entry payload storage; stale contents are masked by valid_q.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem[tail_q] <= addr_b[31:2];
            be_mem[tail_q]   <= addr_b_start;
            data_mem[tail_q] <= addr_b_write;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        assign age_slot_s[g] = head_q + PTR_W'(g);
    end

    // Walk entries oldest to youngest so the youngest matching byte lane wins.
    always_comb begin
        fwd_data_s = mem_rdata;
        for (int k = 0; k < DEPTH; k++) begin
            for (int i = 0; i < 4; i++) begin
                fwd_data_s[8*i +: 8] =
                    (valid_q[age_slot_s[k]] &&
                     (addr_mem[age_slot_s[k]] == addr_b[31:2]) &&
                     be_mem[age_slot_s[k]][i])
                    ? data_mem[age_slot_s[k]][8*i +: 8]
                    : fwd_data_s[8*i +: 8];
            end
        end
    end

    assign addr_b_read = fwd_data_s;
    assign mem_raddr   = addr_b[31:2];
    assign buf_full    = full_s;
    assign buf_empty   = empty_s;
    assign mem_req     = !empty_s;
    assign mem_waddr   = addr_mem[head_q];
    assign mem_be      = be_mem[head_q];
    assign mem_wdata   = data_mem[head_q];
    assign drop_cnt    = drop_q;

endmodule
